dma_rd_desc_split: RTL and testbench
====================================

// Module: dma_rd_desc_split
// PURPOSE
//   Upstream neighbour of the DMA read controller, one instance per client port (CWM, FCWS, ...).
//   Accepts one large read request and splits it into chunks of at most MAX_CHUNK bytes.
//   Issues each chunk as one descriptor on the controller's client port and waits for that chunk's tlast before issuing the next.
//   Merges the returned chunk streams into a single client stream with exactly one tlast.
// PARAMETERS
//   ADDR_W     `DDR_AXI_ADDR_WIDTH   byte address width
//   LEN_W      `DDR_LEN_WIDTH        byte length width
//   DATA_W     `DDR_AXIS_DATA_WIDTH  stream data width
//   MAX_CHUNK  4096                  max bytes per issued descriptor; power of 2, >= DATA_W/8
// PORTS
//   clk           in   1       clock
//   rstn          in   1       synchronous active-low reset
//   s_desc_addr   in   ADDR_W  request start byte address
//   s_desc_len    in   LEN_W   request total byte length
//   s_desc_valid  in   1       request valid
//   s_desc_ready  out  1       high in IDLE only
//   s_rd_tdata    out  DATA_W  merged data to client
//   s_rd_tvalid   out  1       merged data valid
//   s_rd_tlast    out  1       last beat of whole request
//   m_desc_addr   out  ADDR_W  chunk address to read controller
//   m_desc_len    out  LEN_W   chunk length to read controller
//   m_desc_valid  out  1       one-cycle descriptor pulse
//   m_rd_tdata    in   DATA_W  chunk data from read controller
//   m_rd_tvalid   in   1       chunk data valid (no backpressure)
//   m_rd_tlast    in   1       last beat of chunk
//   busy          out  1       state != IDLE
// BEHAVIOUR
//   Reset (rstn=0 at posedge): state=IDLE; every output 0 except s_desc_ready=1; cur_addr/rem cleared.
//   States:
//     IDLE
//       - s_desc_ready=1.
//       - On s_desc_valid: latch cur_addr=addr, rem=len.
//       - Go to ISSUE if len!=0.
//       - Stay in IDLE if len==0: request consumed, no descriptor, no data.
//     ISSUE (exactly 1 cycle)
//       - chunk = min(rem, MAX_CHUNK[, 4K-boundary distance]).
//       - Register m_desc_addr=cur_addr, m_desc_len=chunk, m_desc_valid=1 for this one cycle.
//       - Update cur_addr+=chunk, rem-=chunk, last_chunk=(rem==chunk).
//       - Go to WAIT.
//     WAIT
//       - Forward beats.
//       - On m_rd_tvalid&&m_rd_tlast: go to IDLE if last_chunk, else ISSUE.
//       - The extra ISSUE cycle guarantees the read controller has returned to its idle state.
//   Data path: s_rd_* are registered copies of m_rd_*; latency 1 cycle.
//     - s_rd_tvalid = m_rd_tvalid && state==WAIT.
//     - s_rd_tlast = m_rd_tvalid && m_rd_tlast && last_chunk.
//     - s_rd_tdata is updated only on valid beats.
//   m_rd_tvalid outside WAIT is ignored and not forwarded.
//   s_desc_valid while busy is ignored; the client holds valid until it sees ready.
//   Arithmetic: chunk width LEN_W; cur_addr wraps modulo 2^ADDR_W without error.
//   rem never underflows because chunk <= rem.
//   Reset mid-transfer: returns to IDLE immediately and drops the in-flight chunk.
//     - The read controller and DMA engine share rstn and are reset in the same cycle.
// CONFIGURATION
//   `DMA_SPLIT_4K_EN defined: chunk is additionally limited to 4096 - cur_addr[11:0], so no descriptor crosses a 4 KB boundary.
//   `DMA_SPLIT_4K_EN undefined: chunk = min(rem, MAX_CHUNK); boundaries are ignored.
// STRUCTURE
//   Width macros stay in the shared ../incl.vh header.
//   Add to incl.vh: `DMA_4K_BYTES=4096 and the state encodings IDLE=0, ISSUE=1, WAIT=2 (2-bit).
//   Sub-module: dma_chunk_calc, combinational min of rem / MAX_CHUNK / 4K distance.
//     - Holds all DMA_SPLIT_4K_EN logic.
//     - Its output is registered in ISSUE.
// TESTING
//   1. addr=0x0, len=64, MAX_CHUNK=4096
//      -> 1 m_desc pulse (0x0,64); tlast of the single chunk appears on s_rd_tlast 1 cycle later; busy drops.
//   2. addr=0x0, len=10000
//      -> m_desc pulses (0x0,4096), (0x1000,4096), (0x2000,1808), each only after the previous chunk's tlast.
//      -> exactly one s_rd_tlast.
//   3. With DMA_SPLIT_4K_EN: addr=0xF00, len=512
//      -> (0xF00,256), (0x1000,256).
//      Without DMA_SPLIT_4K_EN -> single (0xF00,512).
//   4. len=0 -> s_desc_ready stays 1; no m_desc_valid; no s_rd_tvalid; busy stays 0.
//   5. Stray m_rd_tvalid in IDLE/ISSUE -> no s_rd_tvalid.
//      s_desc_valid during WAIT -> ignored; no new descriptor.
//   6. rstn=0 mid-chunk 2 of test 2 -> next cycle IDLE, all outputs 0, s_desc_ready=1.
//      A new request then starts cleanly from its own address.

Source files
------------

// File: rtl/dma_rd_desc_split_pkg.sv
// Package: dma_rd_desc_split_pkg
// Purpose : Shared widths, constants and state encoding for the DMA read
//           descriptor splitter and its chunk-size helper.
// Contents:
//   DDR_AXI_ADDR_WIDTH   default byte address width
//   DDR_LEN_WIDTH        default byte length width
//   DDR_AXIS_DATA_WIDTH  default stream data width
//   DMA_4K_BYTES         size of the address window a descriptor may not cross
//   split_state_t        IDLE=0, ISSUE=1, WAIT=2
package dma_rd_desc_split_pkg;

  localparam int DDR_AXI_ADDR_WIDTH  = 32;
  localparam int DDR_LEN_WIDTH       = 32;
  localparam int DDR_AXIS_DATA_WIDTH = 64;
  localparam int DMA_4K_BYTES        = 4096;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } split_state_t;

endpackage

// File: rtl/dma_chunk_calc.sv
// Module : dma_chunk_calc
// Purpose: Combinational size of the next chunk to issue: the smaller of the
//          remaining bytes and MAX_CHUNK and, when the optional feature is
//          built in, the distance to the next 4 KB address boundary.
// Config : `DMA_SPLIT_4K_EN defined -> chunks never cross a 4 KB boundary.
//          `DMA_SPLIT_4K_EN undefined -> boundaries are ignored.
// Ports  :
//   cur_addr  in   ADDR_W  current chunk start byte address
//   rem       in   LEN_W   bytes still to be requested
//   chunk     out  LEN_W   size of the next descriptor
import dma_rd_desc_split_pkg::*;

module dma_chunk_calc #(
  parameter int ADDR_W    = DDR_AXI_ADDR_WIDTH,
  parameter int LEN_W     = DDR_LEN_WIDTH,
  parameter int MAX_CHUNK = DMA_4K_BYTES
) (
  input  logic [ADDR_W-1:0] cur_addr,
  input  logic [LEN_W-1:0]  rem,
  output logic [LEN_W-1:0]  chunk
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_CHUNK);

  logic [LEN_W-1:0] cap;

`ifdef DMA_SPLIT_4K_EN
  // Distance to the next boundary is 1..4096, so it needs 13 bits; an aligned
  // address gives the full 4096.
  logic [12:0]      dist;
  logic [LEN_W-1:0] dist_len;
  logic             unused_addr_hi;

  assign dist           = 13'(DMA_4K_BYTES) - {1'b0, cur_addr[11:0]};
  assign dist_len       = LEN_W'(dist);
  assign unused_addr_hi = ^cur_addr[ADDR_W-1:12];
  assign cap            = (dist_len < MAX_LEN) ? dist_len : MAX_LEN;
`else
  logic unused_addr;

  assign unused_addr = ^cur_addr;
  assign cap         = MAX_LEN;
`endif

  // chunk never exceeds rem, which keeps the remaining count from underflowing.
  assign chunk = (rem < cap) ? rem : cap;

endmodule

// File: rtl/dma_rd_desc_split.sv
// Module : dma_rd_desc_split
// Purpose: Takes one large read request, issues it to the DMA read controller
//          as a sequence of chunk descriptors (one at a time, each after the
//          previous chunk's tlast) and merges the returned chunk streams into
//          one client stream carrying a single tlast.
// Config : `DMA_SPLIT_4K_EN (handled inside dma_chunk_calc) keeps every chunk
//          inside a 4 KB window.
// Ports  :
//   clk, rstn       clock, synchronous active-low reset
//   s_desc_*        client request (addr, len, valid) / ready high in IDLE
//   s_rd_*          merged data to client, registered, 1-cycle latency
//   m_desc_*        chunk descriptor to read controller, 1-cycle valid pulse
//   m_rd_*          chunk data from read controller, no backpressure
//   busy            high whenever a request is in progress
import dma_rd_desc_split_pkg::*;

module dma_rd_desc_split #(
  parameter int ADDR_W    = DDR_AXI_ADDR_WIDTH,
  parameter int LEN_W     = DDR_LEN_WIDTH,
  parameter int DATA_W    = DDR_AXIS_DATA_WIDTH,
  parameter int MAX_CHUNK = DMA_4K_BYTES
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [ADDR_W-1:0] s_desc_addr,
  input  logic [LEN_W-1:0]  s_desc_len,
  input  logic              s_desc_valid,
  output logic              s_desc_ready,
  output logic [DATA_W-1:0] s_rd_tdata,
  output logic              s_rd_tvalid,
  output logic              s_rd_tlast,
  output logic [ADDR_W-1:0] m_desc_addr,
  output logic [LEN_W-1:0]  m_desc_len,
  output logic              m_desc_valid,
  input  logic [DATA_W-1:0] m_rd_tdata,
  input  logic              m_rd_tvalid,
  input  logic              m_rd_tlast,
  output logic              busy
);

  split_state_t     state, state_nxt;
  logic [ADDR_W-1:0] cur_addr;
  logic [LEN_W-1:0]  rem;
  logic [LEN_W-1:0]  chunk;
  logic              last_chunk;
  logic              in_wait;

  dma_chunk_calc #(
    .ADDR_W    (ADDR_W),
    .LEN_W     (LEN_W),
    .MAX_CHUNK (MAX_CHUNK)
  ) u_chunk_calc (
    .cur_addr (cur_addr),
    .rem      (rem),
    .chunk    (chunk)
  );

  assign in_wait      = (state == WAIT);
  assign s_desc_ready = (state == IDLE);
  assign busy         = (state != IDLE);

  // Next-state logic. A zero-length request is consumed in IDLE without
  // ever leaving it. After a non-final chunk we pass through ISSUE again,
  // which also gives the read controller a cycle to settle back to idle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (s_desc_valid && (s_desc_len != '0)) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (m_rd_tvalid && m_rd_tlast) state_nxt = last_chunk ? IDLE : ISSUE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, request bookkeeping, descriptor outputs and the registered data
  // path. Beats arriving outside WAIT are dropped, and tlast is only passed
  // through on the final chunk so the client sees exactly one.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state        <= IDLE;
      cur_addr     <= '0;
      rem          <= '0;
      last_chunk   <= 1'b0;
      m_desc_addr  <= '0;
      m_desc_len   <= '0;
      m_desc_valid <= 1'b0;
      s_rd_tdata   <= '0;
      s_rd_tvalid  <= 1'b0;
      s_rd_tlast   <= 1'b0;
    end else begin
      state        <= state_nxt;
      m_desc_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (s_desc_valid) begin
            cur_addr <= s_desc_addr;
            rem      <= s_desc_len;
          end
        end
        ISSUE: begin
          m_desc_addr  <= cur_addr;
          m_desc_len   <= chunk;
          m_desc_valid <= 1'b1;
          cur_addr     <= cur_addr + ADDR_W'(chunk);
          rem          <= rem - chunk;
          last_chunk   <= (rem == chunk);
        end
        default: ;
      endcase
      s_rd_tvalid <= m_rd_tvalid && in_wait;
      s_rd_tlast  <= m_rd_tvalid && m_rd_tlast && last_chunk && in_wait;
      if (m_rd_tvalid && in_wait) s_rd_tdata <= m_rd_tdata;
    end
  end

endmodule

// File: tb/tb_dma_rd_desc_split.sv
// Testbench: tb_dma_rd_desc_split
// Purpose  : Directed self-checking bench for dma_rd_desc_split with default
//            parameters (32-bit address/length, 64-bit data, 4096-byte chunks).
//            The bench plays the read controller: after each descriptor it
//            returns ceil(len/8) beats, tlast on the final one.
module tb_dma_rd_desc_split;

  logic        clk;
  logic        rstn;
  logic [31:0] s_desc_addr;
  logic [31:0] s_desc_len;
  logic        s_desc_valid;
  logic        s_desc_ready;
  logic [63:0] s_rd_tdata;
  logic        s_rd_tvalid;
  logic        s_rd_tlast;
  logic [31:0] m_desc_addr;
  logic [31:0] m_desc_len;
  logic        m_desc_valid;
  logic [63:0] m_rd_tdata;
  logic        m_rd_tvalid;
  logic        m_rd_tlast;
  logic        busy;

  int          compared;
  int          mismatched;
  int          tlast_seen;
  logic [63:0] beat_val;

  dma_rd_desc_split dut (
    .clk          (clk),
    .rstn         (rstn),
    .s_desc_addr  (s_desc_addr),
    .s_desc_len   (s_desc_len),
    .s_desc_valid (s_desc_valid),
    .s_desc_ready (s_desc_ready),
    .s_rd_tdata   (s_rd_tdata),
    .s_rd_tvalid  (s_rd_tvalid),
    .s_rd_tlast   (s_rd_tlast),
    .m_desc_addr  (m_desc_addr),
    .m_desc_len   (m_desc_len),
    .m_desc_valid (m_desc_valid),
    .m_rd_tdata   (m_rd_tdata),
    .m_rd_tvalid  (m_rd_tvalid),
    .m_rd_tlast   (m_rd_tlast),
    .busy         (busy)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one cycle; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Present one request for a single cycle (the DMA is idle, so it is taken).
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] len);
    s_desc_addr  = addr;
    s_desc_len   = len;
    s_desc_valid = 1'b1;
    checkOutput("ready_before_req", {63'd0, s_desc_ready}, 64'd1);
    tick();
    s_desc_valid = 1'b0;
    if (len != 0) checkOutput("busy_after_req", {63'd0, busy}, 64'd1);
  endtask

  // Wait (bounded) for a descriptor pulse and check its contents.
  task automatic waitDesc(input logic [31:0] addr, input logic [31:0] len);
    int n;
    n = 0;
    while (!m_desc_valid && n < 50) begin
      tick();
      n++;
    end
    checkOutput("desc_seen", {63'd0, m_desc_valid}, 64'd1);
    checkOutput("desc_addr", {32'd0, m_desc_addr}, {32'd0, addr});
    checkOutput("desc_len", {32'd0, m_desc_len}, {32'd0, len});
  endtask

  // Return one chunk's beats and check each forwarded beat one cycle later.
  task automatic streamChunk(input int len, input bit is_last);
    int beats;
    beats = (len + 7) / 8;
    for (int i = 0; i < beats; i++) begin
      beat_val    = 64'hA5A5_0000_0000_0000 + 64'(i) + {32'd0, 32'(len)} * 64'h1_0000;
      m_rd_tdata  = beat_val;
      m_rd_tvalid = 1'b1;
      m_rd_tlast  = (i == beats - 1);
      tick();
      checkOutput("beat_valid", {63'd0, s_rd_tvalid}, 64'd1);
      checkOutput("beat_data", s_rd_tdata, beat_val);
      checkOutput("beat_last", {63'd0, s_rd_tlast}, {63'd0, (is_last && i == beats - 1)});
      checkOutput("no_desc_during_chunk", {63'd0, m_desc_valid}, 64'd0);
      if (s_rd_tlast) tlast_seen++;
    end
    m_rd_tvalid = 1'b0;
    m_rd_tlast  = 1'b0;
    if (is_last) begin
      checkOutput("idle_after_last_busy", {63'd0, busy}, 64'd0);
      checkOutput("idle_after_last_ready", {63'd0, s_desc_ready}, 64'd1);
    end
  endtask

  initial begin
    compared     = 0;
    mismatched   = 0;
    tlast_seen   = 0;
    beat_val     = '0;
    rstn         = 1'b0;
    s_desc_addr  = '0;
    s_desc_len   = '0;
    s_desc_valid = 1'b0;
    m_rd_tdata   = '0;
    m_rd_tvalid  = 1'b0;
    m_rd_tlast   = 1'b0;

    // Reset state
    tick();
    tick();
    checkOutput("rst_ready", {63'd0, s_desc_ready}, 64'd1);
    checkOutput("rst_busy", {63'd0, busy}, 64'd0);
    checkOutput("rst_desc_valid", {63'd0, m_desc_valid}, 64'd0);
    checkOutput("rst_tvalid", {63'd0, s_rd_tvalid}, 64'd0);
    checkOutput("rst_desc_addr", {32'd0, m_desc_addr}, 64'd0);
    rstn = 1'b1;
    tick();

    // Test 1: single small chunk
    $display("[TB] test 1: addr=0 len=64");
    tlast_seen = 0;
    applyStimulus(32'h0, 32'd64);
    waitDesc(32'h0, 32'd64);
    streamChunk(64, 1'b1);
    checkOutput("t1_tlast_count", 64'(tlast_seen), 64'd1);
    tick();

    // Test 2: three chunks, exactly one client tlast
    $display("[TB] test 2: addr=0 len=10000");
    tlast_seen = 0;
    applyStimulus(32'h0, 32'd10000);
    waitDesc(32'h0, 32'd4096);
    streamChunk(4096, 1'b0);
    waitDesc(32'h1000, 32'd4096);
    streamChunk(4096, 1'b0);
    waitDesc(32'h2000, 32'd1808);
    streamChunk(1808, 1'b1);
    checkOutput("t2_tlast_count", 64'(tlast_seen), 64'd1);
    tick();

    // Test 3: request straddling a 4 KB boundary
    $display("[TB] test 3: addr=0xF00 len=512");
    applyStimulus(32'hF00, 32'd512);
`ifdef DMA_SPLIT_4K_EN
    waitDesc(32'hF00, 32'd256);
    streamChunk(256, 1'b0);
    waitDesc(32'h1000, 32'd256);
    streamChunk(256, 1'b1);
`else
    waitDesc(32'hF00, 32'd512);
    streamChunk(512, 1'b1);
`endif
    tick();

    // Test 4: zero-length request is swallowed
    $display("[TB] test 4: len=0");
    s_desc_addr  = 32'h40;
    s_desc_len   = 32'd0;
    s_desc_valid = 1'b1;
    tick();
    s_desc_valid = 1'b0;
    checkOutput("len0_ready", {63'd0, s_desc_ready}, 64'd1);
    checkOutput("len0_busy", {63'd0, busy}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("len0_no_desc", {63'd0, m_desc_valid}, 64'd0);
      checkOutput("len0_no_data", {63'd0, s_rd_tvalid}, 64'd0);
      checkOutput("len0_busy_hold", {63'd0, busy}, 64'd0);
    end

    // Test 5a: stray beat in IDLE is not forwarded
    $display("[TB] test 5: stray beats and ignored requests");
    m_rd_tdata  = 64'hDEAD_BEEF_0000_0001;
    m_rd_tvalid = 1'b1;
    m_rd_tlast  = 1'b1;
    tick();
    m_rd_tvalid = 1'b0;
    m_rd_tlast  = 1'b0;
    checkOutput("stray_idle_tvalid", {63'd0, s_rd_tvalid}, 64'd0);
    checkOutput("stray_idle_tlast", {63'd0, s_rd_tlast}, 64'd0);
    checkOutput("stray_idle_busy", {63'd0, busy}, 64'd0);

    // Test 5b: stray beat during ISSUE is not forwarded and does not end the chunk
    applyStimulus(32'h80, 32'd32);
    m_rd_tvalid = 1'b1;
    m_rd_tlast  = 1'b1;
    tick();
    m_rd_tvalid = 1'b0;
    m_rd_tlast  = 1'b0;
    checkOutput("stray_issue_tvalid", {63'd0, s_rd_tvalid}, 64'd0);
    checkOutput("stray_issue_tlast", {63'd0, s_rd_tlast}, 64'd0);
    waitDesc(32'h80, 32'd32);

    // Test 5c: new request while waiting is ignored
    s_desc_addr  = 32'h5000;
    s_desc_len   = 32'd64;
    s_desc_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("busy_req_no_desc", {63'd0, m_desc_valid}, 64'd0);
      checkOutput("busy_req_not_ready", {63'd0, s_desc_ready}, 64'd0);
    end
    s_desc_valid = 1'b0;
    streamChunk(32, 1'b1);
    tick();

    // Test 6: reset in the middle of chunk 2, then a clean new request
    $display("[TB] test 6: reset mid-transfer");
    applyStimulus(32'h0, 32'd10000);
    waitDesc(32'h0, 32'd4096);
    streamChunk(4096, 1'b0);
    waitDesc(32'h1000, 32'd4096);
    for (int i = 0; i < 5; i++) begin
      m_rd_tdata  = 64'h1234_0000 + 64'(i);
      m_rd_tvalid = 1'b1;
      m_rd_tlast  = 1'b0;
      tick();
    end
    rstn        = 1'b0;
    m_rd_tvalid = 1'b0;
    tick();
    checkOutput("midrst_busy", {63'd0, busy}, 64'd0);
    checkOutput("midrst_ready", {63'd0, s_desc_ready}, 64'd1);
    checkOutput("midrst_desc_valid", {63'd0, m_desc_valid}, 64'd0);
    checkOutput("midrst_desc_addr", {32'd0, m_desc_addr}, 64'd0);
    checkOutput("midrst_desc_len", {32'd0, m_desc_len}, 64'd0);
    checkOutput("midrst_tvalid", {63'd0, s_rd_tvalid}, 64'd0);
    checkOutput("midrst_tlast", {63'd0, s_rd_tlast}, 64'd0);
    checkOutput("midrst_tdata", s_rd_tdata, 64'd0);
    rstn = 1'b1;
    tick();
    tlast_seen = 0;
    applyStimulus(32'h2040, 32'd100);
    waitDesc(32'h2040, 32'd100);
    streamChunk(100, 1'b1);
    checkOutput("t6_tlast_count", 64'(tlast_seen), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
